pingpong_line_reader: RTL and testbench
=======================================

# pingpong_line_reader

Downstream consumer of the CCD ping-pong line buffer write-enable generator. It watches `rama_wren`/`ramb_wren`, detects when a bank finishes a line, and reads that bank's `LINE_LEN` words out as a valid/ready pixel stream with line framing. Reads always target the bank not being written, so the line just written is drained while the next line fills the other bank. It also flags line overruns when a bank is refilled before it has been drained.

## Interface
Parameters:
- `DATA_W`, 12: pixel width in bits.
- `ADDR_W`, 10: RAM address width.
- `LINE_LEN`, 640: words per line; must satisfy 2 ≤ `LINE_LEN` ≤ 2^`ADDR_W`.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `aclr`  in  1  reset, synchronous, active-high.
- `rama_wren`  in  1  bank A write enable from the wren generator.
- `ramb_wren`  in  1  bank B write enable.
- `rama_q`  in  `DATA_W`  bank A read data; 1-cycle registered-address latency.
- `ramb_q`  in  `DATA_W`  bank B read data; same latency.
- `rama_rdaddr`  out  `ADDR_W`  bank A read address.
- `ramb_rdaddr`  out  `ADDR_W`  bank B read address.
- `pix_data`  out  `DATA_W`  output pixel.
- `pix_valid`  out  1  `pix_data` is valid.
- `pix_ready`  in  1  downstream accepts; a transfer occurs when `pix_valid & pix_ready`.
- `line_start`  out  1  qualifies the first pixel of a line.
- `line_end`  out  1  qualifies the last pixel of a line.
- `line_bank`  out  1  source bank of the current pixel: 0 = A, 1 = B.
- `overrun_cnt`  out  8  saturating count of overrun events.

## Operation
- **Edge detection.**
  - Registered copies `wrena_d`/`wrenb_d` are kept.
  - A bank is done when its previous value is 1 and its current value is 0.
  - Done sets `pend_a`/`pend_b`.
- **State machine: `IDLE`, `RD_A`, `RD_B`.**
  - `IDLE`: go to `RD_A` if `pend_a`, else `RD_B` if `pend_b`.
  - If both are pending, serve the bank that completed first. On a same-cycle tie, A goes first.
  - Entering `RD_x` clears `pend_x` and loads the read counter `rcnt` = 0.
  - `RD_x` issues one read per cycle while credit is available and increments `rcnt`.
  - After issuing `rcnt` = `LINE_LEN`-1, return to `IDLE`. If the other bank is pending, go directly to `RD_other`, with no bubble.
- **Addressing.**
  - The read address is `rcnt`, or `LINE_LEN`-1-`rcnt` under the mirror configuration.
  - The address is driven only on the active bank; the idle bank's address holds 0.
- **Buffering.**
  - Read data enters a 2-entry output FIFO.
  - Credit = 2 − occupancy − in-flight reads.
  - A read is issued only if credit > 0. Pixels are therefore never lost under any `pix_ready` pattern.
- **Framing.**
  - `line_start`, `line_end` and `line_bank` are stored per FIFO entry, alongside the data.
- **Overrun.**
  - An overrun is a done event on bank x while `pend_x` is set or the state is `RD_x`.
  - On overrun: `overrun_cnt` increments, saturating at 255. The in-progress read continues unaffected, and `pend_x` is (re)set.
- **Reset.**
  - Outputs: all 0, i.e. `pix_valid`=0, both addresses 0, `overrun_cnt`=0.
  - Internal: state `IDLE`, pend flags and FIFO cleared.
  - `wrena_d`/`wrenb_d` reset to 0, so a wren held high through reset produces no done.
  - Reset mid-line discards the line; no `line_end` is emitted.

## Timing
- Cycle T: the rising edge samples wren=0 with `wren_d`=1; `pend` is set.
- T+1: state `RD_x`, address 0 driven.
- T+2: `q` captured into the FIFO.
- T+3: `pix_valid`=1 with `line_start`=1. First-pixel latency is 3 cycles from the falling wren sample.
- With `pix_ready` held at 1, throughput is 1 pixel/cycle and a line occupies exactly `LINE_LEN` consecutive valid cycles.
- `pix_valid` and `pix_data` are stable while `pix_valid & !pix_ready`.
- Back-to-back lines from alternate banks show no idle cycle between `line_end` and the next `line_start`.

## Configuration
- `PINGPONG_MIRROR_EN` defined: lines are read in descending address order, `LINE_LEN`-1 down to 0, giving a horizontal mirror. `line_start` marks address `LINE_LEN`-1.
- Undefined: ascending order, 0 to `LINE_LEN`-1.
- Latency and framing are otherwise identical.

## Test plan
- **Single line.** `LINE_LEN`=8, bank A preloaded with 0..7, pulse `rama_wren` high for 8 cycles, `pix_ready`=1 → pixels 0..7 on 8 consecutive cycles. First valid appears 3 cycles after wren falls; `line_start` on 0, `line_end` on 7, `line_bank`=0.
- **Ping-pong.** Alternate A (0..7) and B (100..107) lines back-to-back → continuous stream 0..7, 100..107, with `line_bank` toggling and no gap.
- **Backpressure.** Toggle `pix_ready` 1,0,0,1 repeating → all 8 pixels delivered in order with none duplicated; data stays stable while stalled.
- **Overrun.** Complete A twice before its first read finishes → `overrun_cnt`=1 and A is re-read once after the current line completes.
- **Reset mid-line.** Assert `aclr` after the 3rd pixel → next cycle `pix_valid`=0 and all counters are 0. A new A line afterwards reads from address 0.
- **Mirror.** With `PINGPONG_MIRROR_EN` defined, single-line test → output 7..0, with `line_start` on 7.

Source files
------------

// File: rtl/pingpong_line_reader.sv
`default_nettype none
// ============================================================================
// Module   : pingpong_line_reader
// Drains each completed ping-pong bank line as a framed valid/ready pixel
// stream and counts line overruns. Optional macro PINGPONG_MIRROR_EN reads
// each line in descending address order (horizontal mirror).
// Revision : 1.0 - initial release
// ============================================================================
module pingpong_line_reader #(
    parameter int DATA_W   = 12,
    parameter int ADDR_W   = 10,
    parameter int LINE_LEN = 640
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic              rama_wren,
    input  logic              ramb_wren,
    input  logic [DATA_W-1:0] rama_q,
    input  logic [DATA_W-1:0] ramb_q,
    output logic [ADDR_W-1:0] rama_rdaddr,
    output logic [ADDR_W-1:0] ramb_rdaddr,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              line_start,
    output logic              line_end,
    output logic              line_bank,
    output logic [7:0]        overrun_cnt
);
    typedef logic [1:0] state_t;
    localparam state_t            c_IDLE = 2'd0;
    localparam state_t            c_RD_A = 2'd1;
    localparam state_t            c_RD_B = 2'd2;
    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(LINE_LEN - 1);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_rcnt, w_rcnt_nxt, w_addr;
    logic              r_wrena_d, r_wrenb_d, r_pend_a, r_pend_b, r_b_older;
    logic              w_done_a, w_done_b, w_ovr_a, w_ovr_b;
    logic              w_clr_a, w_clr_b, w_keep_a, w_keep_b;
    logic              r_inflight, r_if_start, r_if_end, r_if_bank;
    logic [1:0]        r_occ;
    logic              r_wptr, r_rptr;
    logic [DATA_W-1:0] r_fifo_data [2];
    logic [1:0]        r_fifo_start, r_fifo_end, r_fifo_bank;
    logic [7:0]        r_overrun_cnt;
    logic              w_pop, w_issue, w_reading, w_last;
    logic [2:0]        w_used;
    logic [8:0]        w_ovr_total;

    assign w_done_a  = r_wrena_d & ~rama_wren;
    assign w_done_b  = r_wrenb_d & ~ramb_wren;
    assign w_ovr_a   = w_done_a & (r_pend_a | (r_state == c_RD_A));
    assign w_ovr_b   = w_done_b & (r_pend_b | (r_state == c_RD_B));

    // A slot freed by this cycle's pop is reusable at once, sustaining 1 pixel/cycle.
    assign pix_valid = (r_occ != 2'd0);
    assign w_pop     = pix_valid & pix_ready;
    assign w_used    = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_reading = (r_state == c_RD_A) | (r_state == c_RD_B);
    assign w_issue   = w_reading & (w_used < 3'd2);
    assign w_last    = (r_rcnt == c_LAST);

`ifdef PINGPONG_MIRROR_EN
    assign w_addr = c_LAST - r_rcnt;
`else
    assign w_addr = r_rcnt;
`endif

    assign rama_rdaddr = (r_state == c_RD_A) ? w_addr : '0;
    assign ramb_rdaddr = (r_state == c_RD_B) ? w_addr : '0;
    assign pix_data    = r_fifo_data[r_rptr];
    assign line_start  = r_fifo_start[r_rptr];
    assign line_end    = r_fifo_end[r_rptr];
    assign line_bank   = r_fifo_bank[r_rptr];
    assign overrun_cnt = r_overrun_cnt;

    assign w_keep_a    = r_pend_a & ~w_clr_a;
    assign w_keep_b    = r_pend_b & ~w_clr_b;
    assign w_ovr_total = {1'b0, r_overrun_cnt} + 9'(w_ovr_a) + 9'(w_ovr_b);

    always_comb begin
        w_state_nxt = r_state;
        w_rcnt_nxt  = r_rcnt;
        w_clr_a     = 1'b0;
        w_clr_b     = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (r_pend_a && (!r_pend_b || !r_b_older)) begin
                    w_state_nxt = c_RD_A;
                    w_clr_a     = 1'b1;
                    w_rcnt_nxt  = '0;
                end else if (r_pend_b) begin
                    w_state_nxt = c_RD_B;
                    w_clr_b     = 1'b1;
                    w_rcnt_nxt  = '0;
                end
            end
            c_RD_A: begin
                if (w_issue) begin
                    if (!w_last) begin
                        w_rcnt_nxt = r_rcnt + ADDR_W'(1);
                    end else if (r_pend_b) begin
                        w_state_nxt = c_RD_B;
                        w_clr_b     = 1'b1;
                        w_rcnt_nxt  = '0;
                    end else begin
                        w_state_nxt = c_IDLE;
                        w_rcnt_nxt  = '0;
                    end
                end
            end
            c_RD_B: begin
                if (w_issue) begin
                    if (!w_last) begin
                        w_rcnt_nxt = r_rcnt + ADDR_W'(1);
                    end else if (r_pend_a) begin
                        w_state_nxt = c_RD_A;
                        w_clr_a     = 1'b1;
                        w_rcnt_nxt  = '0;
                    end else begin
                        w_state_nxt = c_IDLE;
                        w_rcnt_nxt  = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_rcnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (aclr) begin
            r_wrena_d      <= 1'b0;
            r_wrenb_d      <= 1'b0;
            r_state        <= c_IDLE;
            r_rcnt         <= '0;
            r_pend_a       <= 1'b0;
            r_pend_b       <= 1'b0;
            r_b_older      <= 1'b0;
            r_inflight     <= 1'b0;
            r_if_start     <= 1'b0;
            r_if_end       <= 1'b0;
            r_if_bank      <= 1'b0;
            r_occ          <= 2'd0;
            r_wptr         <= 1'b0;
            r_rptr         <= 1'b0;
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_start   <= 2'b00;
            r_fifo_end     <= 2'b00;
            r_fifo_bank    <= 2'b00;
            r_overrun_cnt  <= 8'd0;
        end else begin
            r_wrena_d  <= rama_wren;
            r_wrenb_d  <= ramb_wren;
            r_state    <= w_state_nxt;
            r_rcnt     <= w_rcnt_nxt;
            r_pend_a   <= w_keep_a | w_done_a;
            r_pend_b   <= w_keep_b | w_done_b;
            // Age order only changes when one flag survives and the other is fresh.
            r_b_older  <= (w_keep_a & w_keep_b) ? r_b_older : (w_keep_b & ~w_keep_a);
            r_inflight <= w_issue;
            r_if_start <= (r_rcnt == '0);
            r_if_end   <= w_last;
            r_if_bank  <= (r_state == c_RD_B);
            if (r_inflight) begin
                r_fifo_data[r_wptr]  <= r_if_bank ? ramb_q : rama_q;
                r_fifo_start[r_wptr] <= r_if_start;
                r_fifo_end[r_wptr]   <= r_if_end;
                r_fifo_bank[r_wptr]  <= r_if_bank;
                r_wptr               <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_occ         <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
            r_overrun_cnt <= w_ovr_total[8] ? 8'hFF : w_ovr_total[7:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pingpong_line_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_pingpong_line_reader
// Randomised self-checking bench for pingpong_line_reader with a line-level
// reference model (expected pixel stream per completed bank line).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pingpong_line_reader;
    localparam int DATA_W   = 12;
    localparam int ADDR_W   = 10;
    localparam int LINE_LEN = 8;
`ifdef PINGPONG_MIRROR_EN
    localparam bit MIRROR = 1'b1;
`else
    localparam bit MIRROR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              aclr, rama_wren, ramb_wren, pix_ready;
    logic [DATA_W-1:0] rama_q, ramb_q, pix_data;
    logic [ADDR_W-1:0] rama_rdaddr, ramb_rdaddr;
    logic              pix_valid, line_start, line_end, line_bank;
    logic [7:0]        overrun_cnt;

    always #5 clk = ~clk;

    pingpong_line_reader #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .LINE_LEN(LINE_LEN)
    ) dut (
        .clk        (clk),
        .aclr       (aclr),
        .rama_wren  (rama_wren),
        .ramb_wren  (ramb_wren),
        .rama_q     (rama_q),
        .ramb_q     (ramb_q),
        .rama_rdaddr(rama_rdaddr),
        .ramb_rdaddr(ramb_rdaddr),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .line_start (line_start),
        .line_end   (line_end),
        .line_bank  (line_bank),
        .overrun_cnt(overrun_cnt)
    );

    // Bank RAMs with registered read address.
    logic [DATA_W-1:0] mem_a [LINE_LEN];
    logic [DATA_W-1:0] mem_b [LINE_LEN];
    always @(posedge clk) begin
        rama_q <= mem_a[int'(rama_rdaddr) % LINE_LEN];
        ramb_q <= mem_b[int'(ramb_rdaddr) % LINE_LEN];
    end

    typedef struct {
        logic              s;
        logic              e;
        logic              b;
        logic [DATA_W-1:0] d;
        int                cyc;
    } pix_t;

    pix_t got[$];
    pix_t exp_q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   rdy_mode = 0;
    int   rdy_phase = 0;
    logic stall_pend = 1'b0;
    logic [DATA_W-1:0] stall_d = '0;
    int   stall_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Records every accepted pixel and any output change while stalled.
    always @(negedge clk) begin
        if (aclr) begin
            stall_pend <= 1'b0;
        end else begin
            if (stall_pend && (!pix_valid || pix_data !== stall_d)) stall_bad <= stall_bad + 1;
            stall_pend <= pix_valid && !pix_ready;
            stall_d    <= pix_data;
            if (pix_valid && pix_ready)
                got.push_back('{s: line_start, e: line_end, b: line_bank, d: pix_data, cyc: cyc});
        end
    end

    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin
                    pix_ready = (rdy_phase % 4 == 0) || (rdy_phase % 4 == 3);
                    rdy_phase++;
                end
                2:       pix_ready = 1'($urandom_range(0, 1));
                default: pix_ready = 1'b1;
            endcase
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        aclr      = 1'b1;
        rama_wren = 1'b0;
        ramb_wren = 1'b0;
        rdy_mode  = 0;
        step(2);
        aclr = 1'b0;
        got.delete();
        exp_q.delete();
    endtask

    task automatic fill_random();
        for (int i = 0; i < LINE_LEN; i++) begin
            mem_a[i] = DATA_W'($urandom);
            mem_b[i] = DATA_W'($urandom);
        end
    endtask

    task automatic pulse(input logic a, input logic b, input int len, output int fall_cyc);
        rama_wren = a;
        ramb_wren = b;
        step(len);
        rama_wren = 1'b0;
        ramb_wren = 1'b0;
        fall_cyc  = cyc;
    endtask

    task automatic wait_pix(input int n, input int budget, output bit ok);
        int k = 0;
        while (got.size() < n && k < budget) begin
            step(1);
            k++;
        end
        ok = (got.size() >= n);
    endtask

    // Reference: a drained line is LINE_LEN words of its bank in read order.
    function automatic void add_line(input logic bank);
        for (int i = 0; i < LINE_LEN; i++) begin
            int addr = MIRROR ? (LINE_LEN - 1 - i) : i;
            exp_q.push_back('{s: (i == 0), e: (i == LINE_LEN - 1), b: bank,
                              d: bank ? mem_b[addr] : mem_a[addr], cyc: 0});
        end
    endfunction

    function automatic pix_t got_at(input int i);
        pix_t none = '{s: 1'bx, e: 1'bx, b: 1'bx, d: 'x, cyc: -1};
        return (i < got.size()) ? got[i] : none;
    endfunction

    function automatic string fmt(input pix_t p);
        return $sformatf("s=%0b e=%0b b=%0b d=%0h cyc=%0d", p.s, p.e, p.b, p.d, p.cyc);
    endfunction

    function automatic bit same_pix(input pix_t a, input pix_t b);
        return (a.s === b.s) && (a.e === b.e) && (a.b === b.b) && (a.d === b.d);
    endfunction

    task automatic test_reset();
        aclr      = 1'b1;
        rama_wren = 1'b1;
        ramb_wren = 1'b0;
        step(3);
        @(negedge clk);
        n_tests++;
        if ({pix_valid, line_start, line_end, pix_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_pix: valid=%0b start=%0b end=%0b data=%0h, expected all 0",
                     pix_valid, line_start, line_end, pix_data);
        end
        n_tests++;
        if (rama_rdaddr !== '0 || ramb_rdaddr !== '0) begin
            n_fail++;
            $display("FAIL reset_addr: a=%0d b=%0d, expected 0 0", rama_rdaddr, ramb_rdaddr);
        end
        n_tests++;
        if (overrun_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_ovr: got %0d, expected 0", overrun_cnt);
        end
        @(posedge clk);
        #1;
        aclr      = 1'b0;
        rama_wren = 1'b0;
        got.delete();
        step(15);
        n_tests++;
        if (got.size() != 0) begin
            n_fail++;
            $display("FAIL reset_held_wren: got %0d pixels, expected 0", got.size());
        end
    endtask

    task automatic test_single_line();
        int fall;
        bit ok;
        do_reset();
        fill_random();
        add_line(1'b0);
        pulse(1'b1, 1'b0, LINE_LEN, fall);
        wait_pix(LINE_LEN, 60, ok);
        step(6);
        n_tests++;
        if (!ok || got.size() != LINE_LEN) begin
            n_fail++;
            $display("FAIL single_count: got %0d pixels, expected %0d", got.size(), LINE_LEN);
        end
        for (int i = 0; i < LINE_LEN; i++) begin
            pix_t g = got_at(i);
            n_tests++;
            if (!same_pix(g, exp_q[i]) || g.cyc != fall + 4 + i) begin
                n_fail++;
                $display("FAIL single_pix[%0d]: got %s, expected %s with cyc=%0d",
                         i, fmt(g), fmt(exp_q[i]), fall + 4 + i);
            end
        end
    endtask

    task automatic test_pingpong();
        int fa, fb;
        bit ok;
        do_reset();
        for (int i = 0; i < LINE_LEN; i++) begin
            mem_a[i] = DATA_W'(i);
            mem_b[i] = DATA_W'(100 + i);
        end
        add_line(1'b0);
        add_line(1'b1);
        pulse(1'b1, 1'b0, LINE_LEN, fa);
        pulse(1'b0, 1'b1, LINE_LEN, fb);
        wait_pix(2 * LINE_LEN, 80, ok);
        step(6);
        n_tests++;
        if (!ok || got.size() != 2 * LINE_LEN) begin
            n_fail++;
            $display("FAIL pingpong_count: got %0d pixels, expected %0d", got.size(), 2 * LINE_LEN);
        end
        for (int i = 0; i < 2 * LINE_LEN; i++) begin
            pix_t g = got_at(i);
            n_tests++;
            if (!same_pix(g, exp_q[i]) || g.cyc != fa + 4 + i) begin
                n_fail++;
                $display("FAIL pingpong_pix[%0d]: got %s, expected %s with cyc=%0d",
                         i, fmt(g), fmt(exp_q[i]), fa + 4 + i);
            end
        end
    endtask

    task automatic test_backpressure(input int mode, input int nlines);
        int f, base;
        bit ok;
        do_reset();
        fill_random();
        rdy_mode = mode;
        base     = stall_bad;
        for (int l = 0; l < nlines; l++) add_line(1'(l % 2));
        for (int l = 0; l < nlines; l++) pulse(1'(l % 2 == 0), 1'(l % 2 == 1), LINE_LEN, f);
        wait_pix(nlines * LINE_LEN, 400, ok);
        rdy_mode = 0;
        step(8);
        n_tests++;
        if (!ok || got.size() != nlines * LINE_LEN) begin
            n_fail++;
            $display("FAIL bp%0d_count: got %0d pixels, expected %0d", mode, got.size(), nlines * LINE_LEN);
        end
        n_tests++;
        if (stall_bad != base) begin
            n_fail++;
            $display("FAIL bp%0d_stable: got %0d stall changes, expected 0", mode, stall_bad - base);
        end
        for (int i = 0; i < nlines * LINE_LEN; i++) begin
            pix_t g = got_at(i);
            n_tests++;
            if (!same_pix(g, exp_q[i])) begin
                n_fail++;
                $display("FAIL bp%0d_pix[%0d]: got %s, expected %s", mode, i, fmt(g), fmt(exp_q[i]));
            end
        end
    endtask

    task automatic test_overrun();
        int f;
        bit ok;
        do_reset();
        fill_random();
        add_line(1'b0);
        add_line(1'b0);
        pulse(1'b1, 1'b0, LINE_LEN, f);
        step(1);
        pulse(1'b1, 1'b0, 2, f);
        wait_pix(2 * LINE_LEN, 80, ok);
        step(10);
        n_tests++;
        if (overrun_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL overrun_cnt: got %0d, expected 1", overrun_cnt);
        end
        n_tests++;
        if (!ok || got.size() != 2 * LINE_LEN) begin
            n_fail++;
            $display("FAIL overrun_count: got %0d pixels, expected %0d", got.size(), 2 * LINE_LEN);
        end
        for (int i = 0; i < 2 * LINE_LEN; i++) begin
            pix_t g = got_at(i);
            n_tests++;
            if (!same_pix(g, exp_q[i])) begin
                n_fail++;
                $display("FAIL overrun_pix[%0d]: got %s, expected %s", i, fmt(g), fmt(exp_q[i]));
            end
        end
    endtask

    task automatic test_tie();
        int f;
        bit ok;
        do_reset();
        fill_random();
        add_line(1'b0);
        add_line(1'b1);
        pulse(1'b1, 1'b1, LINE_LEN, f);
        wait_pix(2 * LINE_LEN, 80, ok);
        step(6);
        n_tests++;
        if (!ok || got.size() != 2 * LINE_LEN || overrun_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL tie_count: got %0d pixels ovr=%0d, expected %0d ovr=0",
                     got.size(), overrun_cnt, 2 * LINE_LEN);
        end
        for (int i = 0; i < 2 * LINE_LEN; i++) begin
            pix_t g = got_at(i);
            n_tests++;
            if (!same_pix(g, exp_q[i])) begin
                n_fail++;
                $display("FAIL tie_pix[%0d]: got %s, expected %s", i, fmt(g), fmt(exp_q[i]));
            end
        end
    endtask

    task automatic test_reset_midline();
        int f;
        bit ok;
        do_reset();
        fill_random();
        pulse(1'b1, 1'b0, LINE_LEN, f);
        wait_pix(3, 40, ok);
        aclr = 1'b1;
        step(1);
        @(negedge clk);
        n_tests++;
        if (!ok || got.size() != 3 || pix_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_stop: got %0d pixels valid=%0b, expected 3 valid=0", got.size(), pix_valid);
        end
        n_tests++;
        if (rama_rdaddr !== '0 || ramb_rdaddr !== '0 || overrun_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL midreset_state: a=%0d b=%0d ovr=%0d, expected 0 0 0",
                     rama_rdaddr, ramb_rdaddr, overrun_cnt);
        end
        @(posedge clk);
        #1;
        aclr = 1'b0;
        got.delete();
        exp_q.delete();
        fill_random();
        add_line(1'b0);
        pulse(1'b1, 1'b0, LINE_LEN, f);
        wait_pix(LINE_LEN, 60, ok);
        step(6);
        n_tests++;
        if (!ok || got.size() != LINE_LEN) begin
            n_fail++;
            $display("FAIL midreset_count: got %0d pixels, expected %0d", got.size(), LINE_LEN);
        end
        for (int i = 0; i < LINE_LEN; i++) begin
            pix_t g = got_at(i);
            n_tests++;
            if (!same_pix(g, exp_q[i])) begin
                n_fail++;
                $display("FAIL midreset_pix[%0d]: got %s, expected %s", i, fmt(g), fmt(exp_q[i]));
            end
        end
    endtask

    initial begin
        aclr      = 1'b1;
        rama_wren = 1'b0;
        ramb_wren = 1'b0;
        for (int i = 0; i < LINE_LEN; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        test_reset();
        test_single_line();
        test_pingpong();
        test_backpressure(1, 1);
        test_backpressure(2, 3);
        test_overrun();
        test_tie();
        test_reset_midline();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
